// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of committed stores sitting between ROB commit
// and the dmem load/store arbitration FSM. The head entry is presented to dmem
// as a write request until the FSM retires it with store_buffer_pop. A
// combinational overlap check lets the load RS hold back loads that touch a
// buffered store's bytes; there is no forwarding.
module store_buffer #(
    parameter int SB_IDX_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   push_valid,
    input  logic [31:0]            push_addr,
    input  logic [31:0]            push_wdata,
    input  logic [3:0]             push_wmask,
    output logic                   push_ready,

    output logic                   dmem_w_rqst,
    output logic [31:0]            dmem_w_addr,
    output logic [31:0]            dmem_w_wdata,
    output logic [3:0]             dmem_w_wmask,
    input  logic                   store_buffer_pop,

    input  logic [31:0]            load_check_addr,
    input  logic [3:0]             load_check_rmask,
    output logic                   load_conflict,

    output logic [SB_IDX_BITS:0]   sb_count
);

    localparam int DEPTH = 1 << SB_IDX_BITS;
    localparam logic [SB_IDX_BITS:0] PTR_ONE = {{SB_IDX_BITS{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    logic [SB_IDX_BITS:0]   head_q, head_d;
    logic [SB_IDX_BITS:0]   tail_q, tail_d;
    logic [DEPTH-1:0]       valid_q, valid_d;

    // Only the word address is kept; byte position is already in the mask.
    logic [29:0]            ent_addr_q  [DEPTH];
    logic [31:0]            ent_wdata_q [DEPTH];
    logic [3:0]             ent_wmask_q [DEPTH];

    logic [SB_IDX_BITS-1:0] head_idx;
    logic [SB_IDX_BITS-1:0] tail_idx;
    logic                   empty;
    logic                   full;
    logic                   push_fire;
    logic                   pop_fire;
    logic [DEPTH-1:0]       entry_hit;

    // Byte offsets are irrelevant at word granularity; masks carry lane info.
    logic                   unused_addr_lsbs;
    assign unused_addr_lsbs = ^{push_addr[1:0], load_check_addr[1:0]};

    assign head_idx = head_q[SB_IDX_BITS-1:0];
    assign tail_idx = tail_q[SB_IDX_BITS-1:0];

    assign empty = (head_q == tail_q);
    assign full  = (head_idx == tail_idx) && (head_q[SB_IDX_BITS] != tail_q[SB_IDX_BITS]);

    // No pop bypass when full: a full buffer refuses the push even if the head
    // retires in the same cycle, which keeps push_ready off the pop path.
    assign push_ready = !full;
    assign push_fire  = push_valid && !full;
    assign pop_fire   = store_buffer_pop && !empty;

    assign dmem_w_rqst = !empty;
    assign sb_count    = tail_q - head_q;

    // Next pointer and valid state from accepted push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop_fire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end
        if (push_fire) begin
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + PTR_ONE;
        end
    end

    // Pointer and valid registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage, written at the tail on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i]  <= '0;
                ent_wdata_q[i] <= '0;
                ent_wmask_q[i] <= '0;
            end
        end else if (push_fire) begin
            ent_addr_q[tail_idx]  <= push_addr[31:2];
            ent_wdata_q[tail_idx] <= push_wdata;
            ent_wmask_q[tail_idx] <= push_wmask;
        end
    end

    // Head entry drives dmem; outputs are forced to zero while empty so stale
    // payload from retired entries never appears on the bus.
    always_comb begin
        dmem_w_addr  = '0;
        dmem_w_wdata = '0;
        dmem_w_wmask = '0;
        if (!empty) begin
            dmem_w_addr  = {ent_addr_q[head_idx], 2'b00};
            dmem_w_wdata = ent_wdata_q[head_idx];
            dmem_w_wmask = ent_wmask_q[head_idx];
        end
    end

    // Per-entry overlap test against registered state only: an entry being
    // popped this cycle still counts, one being pushed does not until next cycle.
    always_comb begin
        entry_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_hit[i] = valid_q[i]
                           && (ent_addr_q[i] == load_check_addr[31:2])
                           && ((ent_wmask_q[i] & load_check_rmask) != 4'b0000);
        end
    end

    assign load_conflict = |entry_hit;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// push/pop/load-check traffic compared against a queue-based reference model.
module tb_store_buffer;

    localparam int IDX   = 3;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           push_valid;
    logic [31:0]    push_addr;
    logic [31:0]    push_wdata;
    logic [3:0]     push_wmask;
    logic           push_ready;
    logic           dmem_w_rqst;
    logic [31:0]    dmem_w_addr;
    logic [31:0]    dmem_w_wdata;
    logic [3:0]     dmem_w_wmask;
    logic           store_buffer_pop;
    logic [31:0]    load_check_addr;
    logic [3:0]     load_check_rmask;
    logic           load_conflict;
    logic [IDX:0]   sb_count;

    store_buffer #(.SB_IDX_BITS(IDX)) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (push_valid),
        .push_addr        (push_addr),
        .push_wdata       (push_wdata),
        .push_wmask       (push_wmask),
        .push_ready       (push_ready),
        .dmem_w_rqst      (dmem_w_rqst),
        .dmem_w_addr      (dmem_w_addr),
        .dmem_w_wdata     (dmem_w_wdata),
        .dmem_w_wmask     (dmem_w_wmask),
        .store_buffer_pop (store_buffer_pop),
        .load_check_addr  (load_check_addr),
        .load_check_rmask (load_check_rmask),
        .load_conflict    (load_conflict),
        .sb_count         (sb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t model_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_conflict();
        bit c = 1'b0;
        foreach (model_q[i]) begin
            if (model_q[i].addr[31:2] == load_check_addr[31:2] &&
                (model_q[i].mask & load_check_rmask) != 4'b0000)
                c = 1'b1;
        end
        return c;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] ea = '0;
        logic [31:0] ed = '0;
        logic [3:0]  em = '0;
        if (model_q.size() > 0) begin
            ea = {model_q[0].addr[31:2], 2'b00};
            ed = model_q[0].data;
            em = model_q[0].mask;
        end
        check({tag, ".ready"}, 64'(push_ready), 64'(model_q.size() < DEPTH));
        check({tag, ".rqst"},  64'(dmem_w_rqst), 64'(model_q.size() > 0));
        check({tag, ".count"}, 64'(sb_count), 64'(model_q.size()));
        check({tag, ".addr"},  64'(dmem_w_addr), 64'(ea));
        check({tag, ".wdata"}, 64'(dmem_w_wdata), 64'(ed));
        check({tag, ".wmask"}, 64'(dmem_w_wmask), 64'(em));
        check({tag, ".confl"}, 64'(load_conflict), 64'(model_conflict()));
    endtask

    task automatic drive(input bit pv, input logic [31:0] pa, input logic [31:0] pd,
                         input logic [3:0] pm, input bit pop);
        push_valid       = pv;
        push_addr        = pa;
        push_wdata       = pd;
        push_wmask       = pm;
        store_buffer_pop = pop;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        bit push_ok;
        bit pop_ok;
        ent_t e;
        @(posedge clk);
        push_ok = push_valid && (model_q.size() < DEPTH);
        pop_ok  = store_buffer_pop && (model_q.size() > 0);
        if (pop_ok) void'(model_q.pop_front());
        if (push_ok) begin
            e.addr = push_addr;
            e.data = push_wdata;
            e.mask = push_wmask;
            model_q.push_back(e);
        end
        #1;
    endtask

    task automatic cyc(input string tag, input bit pv, input logic [31:0] pa,
                       input logic [31:0] pd, input logic [3:0] pm, input bit pop);
        drive(pv, pa, pd, pm, pop);
        #1;
        check_all(tag);
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        load_check_addr  = '0;
        load_check_rmask = '0;
        drive(0, '0, '0, '0, 0);
        #2;
        check("rst0.ready", 64'(push_ready), 64'd1);
        check("rst0.rqst",  64'(dmem_w_rqst), 64'd0);
        check("rst0.count", 64'(sb_count), 64'd0);
        check("rst0.confl", 64'(load_conflict), 64'd0);
        check("rst0.addr",  64'(dmem_w_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with live entries and a matching load
        cyc("ar.p0", 1, 32'h0000_0500, 32'h1111_1111, 4'hF, 0);
        cyc("ar.p1", 1, 32'h0000_0504, 32'h2222_2222, 4'hF, 0);
        drive(0, '0, '0, '0, 0);
        load_check_addr  = 32'h0000_0500;
        load_check_rmask = 4'b0001;
        #1;
        check("ar.pre_confl", 64'(load_conflict), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar.ready", 64'(push_ready), 64'd1);
        check("ar.rqst",  64'(dmem_w_rqst), 64'd0);
        check("ar.count", 64'(sb_count), 64'd0);
        check("ar.confl", 64'(load_conflict), 64'd0);
        check("ar.addr",  64'(dmem_w_addr), 64'd0);
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        load_check_addr  = '0;
        load_check_rmask = '0;

        // Single store held without pop, then retired
        cyc("s1.push", 1, 32'h0000_1006, 32'hAB00_0000, 4'b1000, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, '0, '0, 0);
            #1;
            check("s1.rqst",  64'(dmem_w_rqst), 64'd1);
            check("s1.addr",  64'(dmem_w_addr), 64'h0000_1004);
            check("s1.wdata", 64'(dmem_w_wdata), 64'hAB00_0000);
            check("s1.wmask", 64'(dmem_w_wmask), 64'h8);
            tick();
        end
        cyc("s1.pop", 0, '0, '0, '0, 1);
        #1;
        check("s1.post_rqst",  64'(dmem_w_rqst), 64'd0);
        check("s1.post_count", 64'(sb_count), 64'd0);

        // Fill, overflow attempt, partial drain/refill across the index wrap
        for (int i = 0; i < DEPTH; i++)
            cyc("fill", 1, 32'h0000_0100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF, 0);
        drive(0, '0, '0, '0, 0);
        #1;
        check("full.ready", 64'(push_ready), 64'd0);
        check("full.count", 64'(sb_count), 64'd8);
        cyc("full.9th", 1, 32'h0000_0DEC, 32'hDEAD_BEEF, 4'hF, 0);
        #1;
        check("full.9th_count", 64'(sb_count), 64'd8);
        for (int i = 0; i < 3; i++) cyc("wrap.pop", 0, '0, '0, '0, 1);
        for (int i = 0; i < 3; i++)
            cyc("wrap.push", 1, 32'h0000_0200 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'h3, 0);
        #1;
        check("wrap.count", 64'(sb_count), 64'd8);
        for (int i = 0; i < DEPTH; i++) cyc("wrap.drain", 0, '0, '0, '0, 1);

        // Simultaneous push and pop at half and at full occupancy
        for (int i = 0; i < 4; i++)
            cyc("sim.fill", 1, 32'h0000_0300 + 32'(4 * i), 32'hE000_0000 + 32'(i), 4'hF, 0);
        cyc("sim.pp4", 1, 32'h0000_0400, 32'hE000_0010, 4'hF, 1);
        #1;
        check("sim.count4", 64'(sb_count), 64'd4);
        check("sim.head4", 64'(dmem_w_addr), 64'h0000_0304);
        for (int i = 0; i < 4; i++)
            cyc("sim.top", 1, 32'h0000_0410 + 32'(4 * i), 32'hE000_0020 + 32'(i), 4'hF, 0);
        cyc("sim.pp8", 1, 32'h0000_0BAD, 32'hBAD0_BAD0, 4'hF, 1);
        #1;
        check("sim.count7", 64'(sb_count), 64'd7);
        for (int i = 0; i < 7; i++) cyc("sim.drain", 0, '0, '0, '0, 1);

        // Overlap check against one entry at 0x2000, mask 0011
        cyc("cf.push", 1, 32'h0000_2000, 32'h0000_5A5A, 4'b0011, 0);
        drive(0, '0, '0, '0, 0);
        load_check_addr = 32'h0000_2002; load_check_rmask = 4'b1100; #1;
        check("cf.2002", 64'(load_conflict), 64'd0);
        load_check_addr = 32'h0000_2001; load_check_rmask = 4'b0010; #1;
        check("cf.2001", 64'(load_conflict), 64'd1);
        load_check_addr = 32'h0000_2004; load_check_rmask = 4'b0001; #1;
        check("cf.2004", 64'(load_conflict), 64'd0);
        load_check_addr = 32'h0000_2001; load_check_rmask = 4'b0010;
        cyc("cf.pop", 0, '0, '0, '0, 1);
        #1;
        check("cf.after_pop", 64'(load_conflict), 64'd0);

        // Pops on an empty buffer are ignored
        for (int i = 0; i < 3; i++) cyc("pe.pop", 0, '0, '0, '0, 1);
        #1;
        check("pe.count", 64'(sb_count), 64'd0);
        cyc("pe.push", 1, 32'h0000_0700, 32'h7777_0000, 4'b0110, 0);
        cyc("pe.pop2", 0, '0, '0, '0, 1);
        cyc("pe.idle", 0, '0, '0, '0, 0);

        // Randomized traffic: push-heavy then pop-heavy phases
        for (int n = 0; n < 1600; n++) begin
            int pp = (n % 400 < 200) ? 70 : 35;
            bit pv = ($urandom_range(0, 99) < pp);
            bit po = ($urandom_range(0, 99) < (100 - pp));
            logic [31:0] pa = 32'h0000_3000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            logic [31:0] pd = $urandom;
            logic [3:0]  pm = 4'($urandom_range(0, 15));
            load_check_addr  = 32'h0000_3000 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            load_check_rmask = 4'($urandom_range(0, 15));
            cyc("rnd", pv, pa, pd, pm, po);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
